// File: rtl/mrd_pkg.sv
// rtl/mrd_pkg.sv - shared state encoding and default latencies for the MR iteration controller
package mrd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RES   = 3'd2,
        S_DIR   = 3'd3,
        S_DOT   = 3'd4,
        S_UPD   = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } mrd_state_e;

    localparam int MV_LAT_DEF  = 2;
    localparam int DOT_LAT_DEF = 2;

endpackage

// File: rtl/mrd_lat_timer.sv
// rtl/mrd_lat_timer.sv - loadable down-counter with zero flag used to time the RES, DIR and DOT phases
module mrd_lat_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load on phase entry, otherwise count down to zero and park there; en=0 freezes the count
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Count register, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mrd_iter_ctrl.sv
// rtl/mrd_iter_ctrl.sv - column/iteration sequencer for the minimal-residual matrix inverse datapath
module mrd_iter_ctrl
    import mrd_pkg::*;
#(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int ITER_NUM  = 2,
    parameter int MV_LAT    = MV_LAT_DEF,
    parameter int DOT_LAT   = DOT_LAT_DEF,
    parameter int ONE       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            col_wr_ready,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(DIMENSION)-1:0]    col_idx,
    output logic [$clog2(ITER_NUM+1)-1:0]   iter_idx,
    output logic [DIMENSION*WIDTH-1:0]      ej,
    output logic                            sel_rj,
    output logic                            m_load,
    output logic                            alpha_en,
    output logic                            upd_en,
    output logic                            col_wr_valid
);

    localparam int CW      = $clog2(DIMENSION);
    localparam int IW      = $clog2(ITER_NUM + 1);
    localparam int LAT_MAX = (MV_LAT > DOT_LAT) ? MV_LAT : DOT_LAT;
    localparam int TW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    // Timer is loaded with LAT-1 so that a phase spends exactly LAT cycles before zero is seen
    localparam logic [TW-1:0] MV_VAL    = TW'(MV_LAT - 1);
    localparam logic [TW-1:0] DOT_VAL   = TW'(DOT_LAT - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(DIMENSION - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER_NUM - 1);

    mrd_state_e    state_q, state_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic [IW-1:0] iter_idx_q, iter_idx_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    mrd_lat_timer #(.W(TW)) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state logic: nothing moves without en, and abort beats every other transition
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        iter_idx_d = iter_idx_q;
        tmr_load   = 1'b0;
        tmr_val    = MV_VAL;
        if (en) begin
            if (abort) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_d    = S_LOAD;
                            col_idx_d  = '0;
                            iter_idx_d = '0;
                        end
                    end
                    S_LOAD: begin
                        state_d  = S_RES;
                        tmr_load = 1'b1;
                    end
                    S_RES: begin
                        if (tmr_zero) begin
                            state_d  = S_DIR;
                            tmr_load = 1'b1;
                        end
                    end
                    S_DIR: begin
                        if (tmr_zero) begin
                            state_d  = S_DOT;
                            tmr_load = 1'b1;
                            tmr_val  = DOT_VAL;
                        end
                    end
                    S_DOT: begin
                        if (tmr_zero) begin
                            state_d = S_UPD;
                        end
                    end
                    S_UPD: begin
                        if (iter_idx_q != ITER_LAST) begin
                            iter_idx_d = iter_idx_q + IW'(1);
                            state_d    = S_RES;
                            tmr_load   = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (col_wr_ready) begin
                            if (col_idx_q == COL_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                col_idx_d  = col_idx_q + CW'(1);
                                iter_idx_d = '0;
                                state_d    = S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // State and counter registers with synchronous active-low reset overriding en
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            col_idx_q  <= '0;
            iter_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            iter_idx_q <= iter_idx_d;
        end
    end

    // Strobes are gated by en so a stall never repeats a load/capture/commit; levels just follow state
    always_comb begin
        busy         = rst && (state_q != S_IDLE);
        done         = rst && en && (state_q == S_DONE);
        m_load       = rst && en && (state_q == S_LOAD);
        alpha_en     = rst && en && (state_q == S_DOT) && tmr_zero;
        upd_en       = rst && en && (state_q == S_UPD);
        sel_rj       = rst && (state_q == S_DIR);
        col_wr_valid = rst && (state_q == S_WRITE);
        col_idx      = col_idx_q;
        iter_idx     = iter_idx_q;
    end

    // Unit vector for the active column, all-zero while idle
    always_comb begin
        ej = '0;
        for (int k = 0; k < DIMENSION; k++) begin
            if (busy && (col_idx_q == CW'(k))) begin
                ej[k*WIDTH +: WIDTH] = WIDTH'(ONE);
            end
        end
    end

endmodule

// File: tb/tb_mrd_iter_ctrl.sv
// tb/tb_mrd_iter_ctrl.sv - directed self-checking bench for mrd_iter_ctrl
module tb_mrd_iter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ready = 1'b1;
    logic start4 = 1'b0;

    logic         busy, done, m_load, alpha_en, upd_en, sel_rj, col_wr_valid;
    logic [3:0]   col_idx;
    logic [1:0]   iter_idx;
    logic [127:0] ej;

    logic         busy4, done4, m_load4, alpha_en4, upd_en4, sel_rj4, col_wr_valid4;
    logic [1:0]   col_idx4;
    logic [0:0]   iter_idx4;
    logic [31:0]  ej4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_v, done_c, nv, na, nu, wr3, na_stall, a11, nd, nv4, bad4;
    logic [31:0] e4;

    always #5 clk = ~clk;

    mrd_iter_ctrl u_dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
        .col_wr_ready(ready), .busy(busy), .done(done), .col_idx(col_idx),
        .iter_idx(iter_idx), .ej(ej), .sel_rj(sel_rj), .m_load(m_load),
        .alpha_en(alpha_en), .upd_en(upd_en), .col_wr_valid(col_wr_valid)
    );

    mrd_iter_ctrl #(.DIMENSION(4), .ITER_NUM(1)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .start(start4), .abort(abort),
        .col_wr_ready(ready), .busy(busy4), .done(done4), .col_idx(col_idx4),
        .iter_idx(iter_idx4), .ej(ej4), .sel_rj(sel_rj4), .m_load(m_load4),
        .alpha_en(alpha_en4), .upd_en(upd_en4), .col_wr_valid(col_wr_valid4)
    );

    function automatic logic [127:0] unit(input int k);
        logic [127:0] v;
        v = '0;
        v[k*8 +: 8] = 8'd1;
        return v;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        // reset overrides en=0
        step();
        step();
        checki("rst_state", int'({busy, done, m_load, alpha_en, upd_en, sel_rj, col_wr_valid}), 0);
        checkn("rst_ej", ej, '0);
        checki("rst_col", int'(col_idx), 0);
        checki("rst_iter", int'(iter_idx), 0);
        rst = 1'b1;
        en  = 1'b1;
        step();
        check1("idle_busy", busy, 1'b0);

        // full run, ready always high, start pulse while busy at cycle 20
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        check1("A_load", m_load, 1'b1);
        checkn("A_ej0", ej, unit(0));
        first_v = -1; done_c = -1; nv = 0; na = 0; nu = 0;
        for (int i = 0; i < 300 && done_c < 0; i++) begin
            step();
            start = (cyc == 20);
            if (col_wr_valid) begin nv++; if (first_v < 0) first_v = cyc; end
            if (alpha_en) na++;
            if (upd_en) nu++;
            if (done) done_c = cyc;
            if (cyc == 2) check1("A_res_sel", sel_rj, 1'b0);
            if (cyc == 4) check1("A_dir_sel", sel_rj, 1'b1);
            if (cyc == 9) checki("A_iter1", int'(iter_idx), 1);
            if (cyc == 17) checkn("A_ej1", ej, unit(1));
        end
        start = 1'b0;
        checki("A_first_valid", first_v, 16);
        checki("A_done_cyc", done_c, 257);
        checki("A_nvalid", nv, 16);
        checki("A_nalpha", na, 32);
        checki("A_nupd", nu, 32);
        step();
        check1("A_idle", busy, 1'b0);
        checkn("A_idle_ej", ej, '0);

        // ready low for 5 valid cycles at column 3
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        done_c = -1; nv = 0; wr3 = 0;
        for (int i = 0; i < 300 && done_c < 0; i++) begin
            step();
            if (m_load && col_idx == 4'd3) ready = 1'b0;
            if (col_wr_valid) nv++;
            if (col_wr_valid && col_idx == 4'd3) begin
                wr3++;
                if (wr3 == 6) ready = 1'b1;
            end
            if (done) done_c = cyc;
        end
        ready = 1'b1;
        checki("B_valid_len", wr3, 6);
        checki("B_nvalid", nv, 21);
        checki("B_done_cyc", done_c, 262);
        step();

        // en low for 4 cycles in DOT of column 0
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        done_c = -1; na = 0; na_stall = 0; a11 = 0;
        for (int i = 0; i < 300 && done_c < 0; i++) begin
            step();
            if (alpha_en) begin
                na++;
                if (cyc >= 6 && cyc <= 10) na_stall++;
                if (cyc == 11) a11 = 1;
            end
            if (cyc == 8) checkn("C_stall_ej", ej, unit(0));
            if (cyc == 12) check1("C_upd_after", upd_en, 1'b1);
            if (done) done_c = cyc;
            if (cyc == 6) en = 1'b0;
            if (cyc == 10) en = 1'b1;
        end
        en = 1'b1;
        checki("C_alpha_stall", na_stall, 0);
        checki("C_alpha_resume", a11, 1);
        checki("C_nalpha", na, 32);
        checki("C_done_cyc", done_c, 261);
        step();

        // abort in DIR of column 7
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        for (int i = 0; i < 200 && !(sel_rj && col_idx == 4'd7); i++) step();
        checki("D_dir7_cyc", cyc, 116);
        abort = 1'b1; step(); abort = 1'b0;
        checki("D_abort_outs", int'({busy, done, sel_rj, col_wr_valid}), 0);
        checkn("D_abort_ej", ej, '0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) nd++;
        end
        checki("D_quiet", nd, 0);

        // restart from column 0, ignore start while busy, reset in UPD of column 10
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        check1("E_load", m_load, 1'b1);
        checki("E_col0", int'(col_idx), 0);
        for (int i = 0; i < 200 && cyc < 168; i++) begin
            step();
            start = (cyc == 3);
        end
        start = 1'b0;
        check1("E_upd10", upd_en, 1'b1);
        checki("E_col10", int'(col_idx), 10);
        rst = 1'b0; step();
        checki("E_rst_outs", int'({busy, done, m_load, alpha_en, upd_en, sel_rj, col_wr_valid}), 0);
        checkn("E_rst_ej", ej, '0);
        checki("E_rst_cnt", int'({col_idx, iter_idx}), 0);
        rst = 1'b1;
        start = 1'b1; cyc = 0; step(); start = 1'b0;
        check1("E_reload", m_load, 1'b1);
        for (int i = 0; i < 40 && cyc < 16; i++) begin
            step();
            start = (cyc == 5);
        end
        start = 1'b0;
        check1("E_write0", col_wr_valid, 1'b1);
        abort = 1'b1; step(); abort = 1'b0;
        checki("E_abort_write", int'({busy, m_load, col_wr_valid}), 0);

        // DIMENSION=4, ITER_NUM=1 instance: 9-cycle columns
        start4 = 1'b1; cyc = 0; step(); start4 = 1'b0;
        done_c = -1; nv4 = 0; bad4 = 0;
        for (int i = 0; i < 40; i++) begin
            if (cyc % 9 == 1 && cyc <= 28) begin
                e4 = 32'h1 << (8 * ((cyc - 1) / 9));
                check1("F_mload", m_load4, 1'b1);
                checkn("F_ej", {96'h0, ej4}, {96'h0, e4});
            end
            if (col_wr_valid4) begin
                nv4++;
                if (cyc % 9 != 0) bad4++;
            end
            if (done4) done_c = cyc;
            step();
        end
        checki("F_nvalid", nv4, 4);
        checki("F_valid_pos", bad4, 0);
        checki("F_done_cyc", done_c, 37);
        check1("F_idle", busy4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mrd_iter_ctrl.md
MRD_ITER_CTRL -- requirements
Module: mrd_iter_ctrl

Interface
REQ-001 Parameter DIMENSION, 16, matrix order and number of columns to solve.
REQ-002 Parameter WIDTH, 8, bits per vector element.
REQ-003 Parameter ITER_NUM, 2, minimal-residual iterations per column; legal range 1 or more.
REQ-004 Parameter MV_LAT, 2, cycles from matrix-vector operand select to valid MV result.
REQ-005 Parameter DOT_LAT, 2, cycles from dot-product operands to valid fenzi/fenmu.
REQ-006 Parameter ONE, 1, signed value placed in the active element of ej.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 en  in  1  global enable; low freezes all state.
REQ-010 start  in  1  begin solving all DIMENSION columns; sampled in IDLE only.
REQ-011 abort  in  1  cancel the current run.
REQ-012 col_wr_ready  in  1  downstream accepts a finished column.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when the last column is accepted.
REQ-015 col_idx  out  $clog2(DIMENSION)  current column j.
REQ-016 iter_idx  out  $clog2(ITER_NUM+1)  current iteration within the column.
REQ-017 ej  out  DIMENSION*WIDTH  unit vector; element k is bits [k*WIDTH +: WIDTH].
REQ-018 sel_rj  out  1  datapath MUX select; 0 selects Mi, 1 selects rj.
REQ-019 m_load  out  1  load M_init into the iterate register.
REQ-020 alpha_en  out  1  capture alpha from fenzi/fenmu.
REQ-021 upd_en  out  1  commit M <= M + alpha*rj.
REQ-022 col_wr_valid  out  1  finished column is available on M_iter.

Function
REQ-023 FSM states SHALL be IDLE, LOAD, RES, DIR, DOT, UPD, WRITE and DONE.
REQ-024 IDLE SHALL go to LOAD when start=1 and en=1; col_idx and iter_idx SHALL clear.
REQ-025 LOAD SHALL last 1 cycle with m_load=1, then go to RES.
REQ-026 RES SHALL last MV_LAT cycles with sel_rj=0 (residual r = ej - A*M), then go to DIR.
REQ-027 DIR SHALL last MV_LAT cycles with sel_rj=1 (A*r), then go to DOT.
REQ-028 DOT SHALL last DOT_LAT cycles, with alpha_en=1 on its final cycle, then go to UPD.
REQ-029 UPD SHALL last 1 cycle with upd_en=1.
REQ-030 UPD SHALL increment iter_idx and go to RES if iter_idx<ITER_NUM-1; otherwise it SHALL go to WRITE.
REQ-031 WRITE SHALL hold col_wr_valid=1 until col_wr_ready=1 with en=1.
REQ-032 On acceptance in WRITE, if col_idx=DIMENSION-1 the FSM SHALL go to DONE; otherwise col_idx SHALL increment, iter_idx SHALL clear and the FSM SHALL go to LOAD.
REQ-033 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-034 ej SHALL carry ONE in element col_idx and zero elsewhere while busy, and SHALL be all-zero in IDLE.
REQ-035 sel_rj SHALL be 0 outside DIR.
REQ-036 With en=0, state, counters and latency timers SHALL hold, and m_load, alpha_en, upd_en and done SHALL be forced to 0.
REQ-037 With en=0, col_wr_valid, sel_rj and ej SHALL hold their values.
REQ-038 start while busy SHALL be ignored.
REQ-039 abort=1 with en=1 SHALL force IDLE on the next edge, with no done pulse and no col_wr_valid afterwards.
REQ-040 abort SHALL take priority over all other transitions, including col_wr_ready in WRITE.
REQ-041 Per-column cost SHALL be 2 + ITER_NUM*(2*MV_LAT + DOT_LAT + 1) cycles with col_wr_ready held high; this is 16 with default parameters.

Reset
REQ-042 rst=0 at a clock edge SHALL force IDLE and set col_idx=0, iter_idx=0 and all timers to 0.
REQ-043 During reset, busy, done, m_load, alpha_en, upd_en, sel_rj and col_wr_valid SHALL be 0, and ej SHALL be 0.
REQ-044 Reset SHALL override en, and mid-run reset SHALL behave identically to reset from IDLE.

Structure
REQ-045 Package mrd_pkg SHALL hold the state encoding and the default MV_LAT and DOT_LAT constants.
REQ-046 The phase timer SHALL be one sub-module, mrd_lat_timer: a loadable down-counter with en and a zero flag, reused for the RES, DIR and DOT phases.

Verification
REQ-047 Defaults, col_wr_ready=1, start pulse at cycle 0: LOAD at cycle 1, first col_wr_valid at cycle 16, done at cycle 257, 16 col_wr_valid pulses.
REQ-048 col_wr_ready held low 5 cycles at column 3: col_wr_valid stays high 6 cycles, col_idx stays 3, done is delayed by 5 cycles.
REQ-049 en low for 4 cycles in DOT of column 0: alpha_en is absent during the stall, occurs once after, and total cycles grow by exactly 4.
REQ-050 abort in DIR of column 7: IDLE next cycle, busy=0, ej=0, no done; a new start resumes from col_idx=0.
REQ-051 rst=0 in UPD of column 10: all outputs 0 on the next edge; start pulses while busy are ignored.
REQ-052 ITER_NUM=1, DIMENSION=4: each column takes 9 cycles; ej walks 0x01, 0x0100, 0x010000, 0x01000000 in the low 32 bits.
